// File: rtl/icb_sram_responder_pkg.sv
// Shared types and address helpers for the ICB SRAM responder.
// Address helpers work on a 64-bit view so any ADDR_W up to 64 fits.
package icb_sram_responder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WBURST = 2'd1,
    RBURST = 2'd2,
    WRSP   = 2'd3
  } icb_state_e;

  localparam int unsigned ICB_WIDTH_DEF = 32;
  localparam int unsigned ICB_DW        = ICB_WIDTH_DEF / 8;

  function automatic logic [63:0] addr_to_word(input logic [63:0] addr,
                                               input int unsigned lg_dw,
                                               input int unsigned depth_w);
    logic [63:0] mask;
    mask = (64'd1 << depth_w) - 64'd1;
    return (addr >> lg_dw) & mask;
  endfunction

  function automatic logic addr_oor(input logic [63:0] addr,
                                    input int unsigned lg_dw,
                                    input int unsigned depth_w);
    return (addr >> (lg_dw + depth_w)) != 64'd0;
  endfunction

endpackage

// File: rtl/icb_sram_responder_if.sv
// ICB command/response channel bundle with master and slave views.
interface icb_sram_responder_if #(
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 32,
  parameter int ICB_LEN_W = 3
);
  logic                  icb_cmd_valid;
  logic                  icb_cmd_ready;
  logic [ADDR_W-1:0]     icb_cmd_addr;
  logic                  icb_cmd_read;
  logic [ICB_LEN_W-1:0]  icb_cmd_len;
  logic [WIDTH-1:0]      icb_cmd_wdata;
  logic [WIDTH/8-1:0]    icb_cmd_wmask;
  logic                  icb_rsp_valid;
  logic                  icb_rsp_ready;
  logic [WIDTH-1:0]      icb_rsp_rdata;
  logic                  icb_rsp_err;
  logic                  icb_rsp_last;

  modport master (
    output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_len,
           icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err, icb_rsp_last
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_len,
           icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err, icb_rsp_last
  );
endinterface

// File: rtl/icb_sram_responder_sram.sv
// Single-port synchronous RAM with per-byte write enables and a 1-cycle read.
// Read data register only updates on a read, so it holds across stalls and writes.
module sram_1rw_be #(
  parameter int WIDTH   = 32,
  parameter int DEPTH_W = 10
) (
  input  logic                 clk,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [DEPTH_W-1:0]   addr_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic [WIDTH/8-1:0]   be_i,
  output logic [WIDTH-1:0]     rdata_o
);
  logic [WIDTH-1:0] mem_q [2**DEPTH_W];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < WIDTH/8; i++) begin
          if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/icb_sram_responder.sv
// ICB slave backed by a byte-enabled SRAM: single/incrementing bursts, one
// write response per transaction, one read response beat per SRAM read.
module icb_sram_responder
  import icb_sram_responder_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 32,
  parameter int ICB_LEN_W = 3,
  parameter int DEPTH_W   = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  icb_sram_responder_if.slave   icb
);
  localparam int unsigned DW    = WIDTH / 8;
  localparam int unsigned LG_DW = (DW > 1) ? $clog2(DW) : 0;
  localparam int          CNT_W = ICB_LEN_W + 1;

  icb_state_e             state_q;
  logic                   cmd_ready_q;
  logic                   rsp_valid_q;
  logic                   rsp_err_q;
  logic                   rsp_last_q;
  logic                   rsp_rd_sel_q;
  logic                   oor_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [ICB_LEN_W-1:0]   len_q;
  logic [DEPTH_W-1:0]     ptr_q;

  logic [63:0]            cmd_addr_ext;
  logic [DEPTH_W-1:0]     start_word;
  logic                   start_oor;
  logic                   cmd_hs;
  logic                   rsp_hs;
  logic                   rd_issue;

  logic                   ram_en;
  logic                   ram_we;
  logic [DEPTH_W-1:0]     ram_addr;
  logic [WIDTH-1:0]       ram_rdata;

  assign cmd_addr_ext = 64'(icb.icb_cmd_addr);
  assign start_word   = DEPTH_W'(addr_to_word(cmd_addr_ext, LG_DW, DEPTH_W));
  assign start_oor    = addr_oor(cmd_addr_ext, LG_DW, DEPTH_W);

  assign cmd_hs   = icb.icb_cmd_valid & cmd_ready_q;
  assign rsp_hs   = rsp_valid_q & icb.icb_rsp_ready;
  // A read is launched only when the output slot is free or being drained this cycle.
  assign rd_issue = (state_q == RBURST) && (cnt_q != '0) &&
                    (!rsp_valid_q || icb.icb_rsp_ready);

  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = ptr_q;
    case (state_q)
      IDLE: begin
        if (cmd_hs && !icb.icb_cmd_read && !start_oor) begin
          ram_en   = 1'b1;
          ram_we   = 1'b1;
          ram_addr = start_word;
        end
      end
      WBURST: begin
        if (cmd_hs && !oor_q) begin
          ram_en = 1'b1;
          ram_we = 1'b1;
        end
      end
      RBURST: begin
        if (rd_issue && !oor_q) ram_en = 1'b1;
      end
      default: ;
    endcase
  end

  sram_1rw_be #(
    .WIDTH   (WIDTH),
    .DEPTH_W (DEPTH_W)
  ) u_sram (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (icb.icb_cmd_wdata),
    .be_i    (icb.icb_cmd_wmask),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_last_q   <= 1'b0;
      rsp_rd_sel_q <= 1'b0;
      oor_q        <= 1'b0;
      cnt_q        <= '0;
      len_q        <= '0;
      ptr_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_hs) begin
            len_q <= icb.icb_cmd_len;
            oor_q <= start_oor;
            if (icb.icb_cmd_read) begin
              ptr_q       <= start_word;
              cnt_q       <= {1'b0, icb.icb_cmd_len} + CNT_W'(1);
              cmd_ready_q <= 1'b0;
              state_q     <= RBURST;
            end else begin
              // Beat 0 is written on this edge; cnt_q becomes the next beat index.
              ptr_q <= start_word + DEPTH_W'(1);
              cnt_q <= CNT_W'(1);
              if (icb.icb_cmd_len == '0) begin
                cmd_ready_q  <= 1'b0;
                rsp_valid_q  <= 1'b1;
                rsp_last_q   <= 1'b1;
                rsp_err_q    <= start_oor;
                rsp_rd_sel_q <= 1'b0;
                state_q      <= WRSP;
              end else begin
                state_q <= WBURST;
              end
            end
          end
        end
        WBURST: begin
          if (cmd_hs) begin
            ptr_q <= ptr_q + DEPTH_W'(1);
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == {1'b0, len_q}) begin
              cmd_ready_q  <= 1'b0;
              rsp_valid_q  <= 1'b1;
              rsp_last_q   <= 1'b1;
              rsp_err_q    <= oor_q;
              rsp_rd_sel_q <= 1'b0;
              state_q      <= WRSP;
            end
          end
        end
        RBURST: begin
          if (rd_issue) begin
            ptr_q        <= ptr_q + DEPTH_W'(1);
            cnt_q        <= cnt_q - CNT_W'(1);
            rsp_valid_q  <= 1'b1;
            rsp_last_q   <= (cnt_q == CNT_W'(1));
            rsp_err_q    <= oor_q;
            rsp_rd_sel_q <= !oor_q;
          end else if (rsp_hs) begin
            rsp_valid_q <= 1'b0;
            if (rsp_last_q) begin
              rsp_last_q   <= 1'b0;
              rsp_err_q    <= 1'b0;
              rsp_rd_sel_q <= 1'b0;
              cmd_ready_q  <= 1'b1;
              state_q      <= IDLE;
            end
          end
        end
        WRSP: begin
          if (rsp_hs) begin
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign icb.icb_cmd_ready = cmd_ready_q;
  assign icb.icb_rsp_valid = rsp_valid_q;
  assign icb.icb_rsp_rdata = rsp_rd_sel_q ? ram_rdata : '0;
  assign icb.icb_rsp_err   = rsp_err_q;
  assign icb.icb_rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_icb_sram_responder.sv
// Directed bench for icb_sram_responder: vector table of single beats plus
// burst, backpressure, wrap and mid-burst reset sequences against a byte shadow.
module tb_icb_sram_responder;

  logic clk;
  logic rst_n;

  icb_sram_responder_if #(.WIDTH(32), .ADDR_W(32), .ICB_LEN_W(3)) icb ();

  icb_sram_responder #(
    .WIDTH(32), .ADDR_W(32), .ICB_LEN_W(3), .DEPTH_W(10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .icb   (icb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  golden_mem_sa [4096];
  logic [31:0] wd [8];
  logic [3:0]  wm [8];

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [7:0] read_byte(input int a);
    return golden_mem_sa[a % 4096];
  endfunction

  function automatic logic [31:0] gold_word(input int w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = read_byte((w % 1024) * 4 + b);
    return r;
  endfunction

  task automatic gold_write(input int w, input logic [31:0] d, input logic [3:0] m);
    for (int b = 0; b < 4; b++)
      if (m[b]) golden_mem_sa[(w % 1024) * 4 + b] = d[8*b +: 8];
  endtask

  task automatic cmd_beat(input logic [31:0] a, input logic rd, input logic [2:0] len,
                          input logic [31:0] d, input logic [3:0] m);
    int t;
    icb.icb_cmd_valid = 1'b1;
    icb.icb_cmd_addr  = a;
    icb.icb_cmd_read  = rd;
    icb.icb_cmd_len   = len;
    icb.icb_cmd_wdata = d;
    icb.icb_cmd_wmask = m;
    t = 0;
    @(negedge clk);
    while (!icb.icb_cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!icb.icb_cmd_ready) begin
      n_checks++;
      $display("FAIL cmd_timeout: cmd_ready stayed %b, required 1", icb.icb_cmd_ready);
    end
    @(posedge clk);
    #1;
    icb.icb_cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input string nm, input logic [31:0] er, input logic ee, input logic el);
    int t;
    t = 0;
    @(negedge clk);
    while (!icb.icb_rsp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!icb.icb_rsp_valid) begin
      n_checks++;
      $display("FAIL %s_timeout: rsp_valid stayed 0, required 1", nm);
    end else begin
      chk({nm, "_rdata"}, icb.icb_rsp_rdata, er);
      chk({nm, "_err"}, 32'(icb.icb_rsp_err), 32'(ee));
      chk({nm, "_last"}, 32'(icb.icb_rsp_last), 32'(el));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input string nm, input logic [31:0] a, input logic [2:0] len);
    logic oor;
    oor = (a >> 12) != 0;
    for (int i = 0; i <= int'(len); i++) begin
      cmd_beat(a, 1'b0, len, wd[i], wm[i]);
      if (!oor) gold_write(int'(a >> 2) + i, wd[i], wm[i]);
    end
    get_rsp(nm, 32'h0, oor, 1'b1);
  endtask

  task automatic do_read(input string nm, input logic [31:0] a, input logic [2:0] len);
    cmd_beat(a, 1'b1, len, 32'h0, 4'h0);
    for (int i = 0; i <= int'(len); i++)
      get_rsp(nm, gold_word(int'((a >> 2) & 32'h3FF) + i), 1'b0, i == int'(len));
  endtask

  initial begin
    int got;
    int t;
    logic [31:0] held;
    logic        prev_stall;

    for (int i = 0; i < 4096; i++) golden_mem_sa[i] = 8'h00;
    icb.icb_cmd_valid = 1'b0;
    icb.icb_cmd_addr  = '0;
    icb.icb_cmd_read  = 1'b0;
    icb.icb_cmd_len   = '0;
    icb.icb_cmd_wdata = '0;
    icb.icb_cmd_wmask = '0;
    icb.icb_rsp_ready = 1'b1;

    // rd, addr, wdata, wmask, exp_rdata, exp_err
    vecs[0] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'hA5A5_1234, 4'h5, 32'h0000_0000, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0010, 32'h0,         4'h0, 32'h00A5_0034, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_0013, 32'hFF00_0000, 4'h8, 32'h0000_0000, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_0011, 32'h0,         4'h0, 32'hFFA5_0034, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_0000, 32'h1122_3344, 4'hF, 32'h0000_0000, 1'b0};
    vecs[6] = '{1'b0, 32'h0001_0000, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b1};
    vecs[7] = '{1'b1, 32'h0001_0000, 32'h0,         4'h0, 32'h0000_0000, 1'b1};
    vecs[8] = '{1'b1, 32'h0000_0000, 32'h0,         4'h0, 32'h1122_3344, 1'b0};
    vecs[9] = '{1'b1, 32'h0000_0012, 32'h0,         4'h0, 32'hFFA5_0034, 1'b0};

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(icb.icb_cmd_ready), 32'h0);
    chk("rst_rsp_valid", 32'(icb.icb_rsp_valid), 32'h0);
    chk("rst_rsp_rdata", icb.icb_rsp_rdata, 32'h0);
    chk("rst_rsp_err",   32'(icb.icb_rsp_err), 32'h0);
    chk("rst_rsp_last",  32'(icb.icb_rsp_last), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_cmd_ready", 32'(icb.icb_cmd_ready), 32'h1);

    for (int v = 0; v < 10; v++) begin
      if (vecs[v].rd) begin
        cmd_beat(vecs[v].addr, 1'b1, 3'd0, 32'h0, 4'h0);
        get_rsp($sformatf("vec%0d_rd", v), vecs[v].exp_rdata, vecs[v].exp_err, 1'b1);
      end else begin
        cmd_beat(vecs[v].addr, 1'b0, 3'd0, vecs[v].wdata, vecs[v].wmask);
        if (!vecs[v].exp_err)
          gold_write(int'((vecs[v].addr >> 2) & 32'h3FF), vecs[v].wdata, vecs[v].wmask);
        get_rsp($sformatf("vec%0d_wr", v), 32'h0, vecs[v].exp_err, 1'b1);
      end
    end

    // Write burst len=3 at 0x40, then read it back with a latency check.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); wm[i] = 4'hF; end
    do_write("wburst40", 32'h40, 3'd3);
    cmd_beat(32'h40, 1'b1, 3'd3, 32'h0, 4'h0);
    chk("rd_lat_edge0", 32'(icb.icb_rsp_valid), 32'h0);
    @(posedge clk);
    #1;
    chk("rd_lat_edge1", 32'(icb.icb_rsp_valid), 32'h1);
    for (int i = 0; i < 4; i++)
      get_rsp($sformatf("rburst40_b%0d", i), 32'(i + 1), 1'b0, i == 3);

    // Read burst len=7 with rsp_ready toggling 1010...
    for (int i = 0; i < 8; i++) begin wd[i] = 32'hC0DE_0100 + 32'(i); wm[i] = 4'hF; end
    do_write("wburst80", 32'h80, 3'd7);
    cmd_beat(32'h80, 1'b1, 3'd7, 32'h0, 4'h0);
    got = 0;
    held = '0;
    prev_stall = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      icb.icb_rsp_ready = (cyc % 2 == 0);
      @(negedge clk);
      if (icb.icb_rsp_valid) begin
        if (prev_stall) chk("stall_hold", icb.icb_rsp_rdata, held);
        if (icb.icb_rsp_ready) begin
          chk($sformatf("stall_beat%0d", got), icb.icb_rsp_rdata, gold_word(32 + got));
          chk($sformatf("stall_last%0d", got), 32'(icb.icb_rsp_last), 32'(got == 7));
          got++;
          prev_stall = 1'b0;
        end else begin
          held = icb.icb_rsp_rdata;
          prev_stall = 1'b1;
        end
      end else begin
        prev_stall = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    icb.icb_rsp_ready = 1'b1;
    chk("stall_beat_count", 32'(got), 32'd8);

    // Burst wrap from word 1023 to word 0.
    wd[0] = 32'hAAAA_0001; wm[0] = 4'hF;
    wd[1] = 32'hBBBB_0002; wm[1] = 4'hF;
    do_write("wrap_wr", 32'hFFC, 3'd1);
    cmd_beat(32'h000, 1'b1, 3'd0, 32'h0, 4'h0);
    get_rsp("wrap_word0", 32'hBBBB_0002, 1'b0, 1'b1);
    do_read("wrap_word1023", 32'hFFC, 3'd0);

    // Reset during beat 2 of a read len=7.
    for (int i = 0; i < 8; i++) begin wd[i] = 32'h5000 + 32'(i); wm[i] = 4'hF; end
    do_write("wburst100", 32'h100, 3'd7);
    cmd_beat(32'h100, 1'b1, 3'd7, 32'h0, 4'h0);
    got = 0;
    t = 0;
    while (got < 2 && t < 40) begin
      @(negedge clk);
      if (icb.icb_rsp_valid) got++;
      t++;
    end
    chk("mid_rst_reached_beat2", 32'(got), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 32'(icb.icb_rsp_valid), 32'h0);
    chk("mid_rst_cmd_ready", 32'(icb.icb_cmd_ready), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_read("after_rst_rd104", 32'h104, 3'd0);
    do_read("after_rst_rd100", 32'h100, 3'd7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded, required finish");
    $fatal(1);
  end

endmodule
